hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 3-stage RV32I core: the consumer side of the forward/flush decision. It compares the decode-stage instruction against the execute-stage instruction every cycle. From that comparison it inserts load-use stalls, kills wrong-path instructions on a taken branch or jump, and drives the PC, IF/ID and ID/EX register controls. It also registers the operand-forward selects so they arrive aligned with the instruction as it enters execute.

## Interface
Parameters:
- LOAD_LAT, 1: number of stall cycles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_d  in  32  instruction word in decode (stage 2).
- inst_e  in  32  instruction word in execute (stage 3).
- reg_write_e  in  1  execute instruction writes the register file.
- br_taken  in  1  branch/JAL/JALR in execute resolved taken this cycle.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load NOP into IF/ID at the next edge.
- idex_flush  out  1  load NOP (bubble) into ID/EX at the next edge.
- for_a_e  out  1  registered: execute operand A takes the writeback result.
- for_b_e  out  1  registered: execute operand B takes the writeback result.
- stall  out  1  load-use stall active this cycle.

## Operation
- **Field decode.** Fields are opcode[6:0], rd[11:7], rs1[19:15] and rs2[24:20].
  - inst_d uses rs1 unless its opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - inst_d uses rs2 only for opcodes 0110011, 0100011 and 1100011.
- **Producer match.** Requires reg_write_e=1, rd_e≠0, and a used source of inst_d equal to rd_e.
  - Forwardable producer: opcode_e in {0110011, 0010011, 0110111, 0010111}.
  - Load producer: opcode_e = 0000011.
  - All other opcodes never match.
- **State machine (RUN, LDSTALL).**
  - RUN, br_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Next state RUN.
  - RUN, load match, no br_taken: stall=1, pc_en=0, ifid_en=0, idex_flush=1. Load the counter with LOAD_LAT-1.
    - If LOAD_LAT=1, stay in RUN.
    - Otherwise go to LDSTALL.
  - RUN, otherwise: pc_en=1, ifid_en=1, no flushes.
  - LDSTALL: same outputs as the stalling RUN cycle. Decrement the counter; return to RUN when it reaches 0.
  - LDSTALL, br_taken=1: abort the stall and take the RUN br_taken behaviour. Next state RUN, counter cleared. (This cannot occur legally; the abort is defined for robustness.)
- **Priority.** br_taken > load-use stall > forward.
- **Forward select registers.**
  - At each edge, for_a_e <= rs1 forwardable match and for_b_e <= rs2 forwardable match, but only when ID/EX advances (ifid_en=1 and idex_flush=0).
  - When idex_flush=1, both are cleared to 0.
  - rs1 and rs2 matches are independent; both may be 1.
  - Load matches never set for_*_e, because the result is already written back once the stall ends.

## Timing
- **Reset.** While rst_n=0:
  - state=RUN, counter=0, for_a_e=0, for_b_e=0.
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, stall=0.
- **Release.** Outputs follow the rules above from the first cycle with rst_n=1. Reset asserted mid-stall returns immediately to the reset values.
- **Combinational outputs.** pc_en, ifid_en, ifid_flush, idex_flush and stall are combinational from state, counter and inputs. Zero-cycle latency.
- **Registered outputs.** for_a_e and for_b_e update at the rising edge and are valid for the cycle in which the instruction is in execute.
- **Load-use duration.** A load-use hazard holds the PC and IF/ID for exactly LOAD_LAT cycles and inserts LOAD_LAT bubbles.
- **Decode change.** An inst_d change during LDSTALL is illegal: IF/ID is frozen, so it cannot legitimately change.

## Configuration
- Macro HAZARD_CTRL_PERF_EN.
- **Defined:** adds 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments every cycle stall=1.
  - flush_cnt increments every cycle ifid_flush=1 with rst_n=1.
  - Both reset to 0 and wrap modulo 2^32.
- **Undefined:** no ports, no counters; all other behaviour is identical.

## Test plan
- **Reset.** Assert rst_n=0 mid-run -> pc_en=0, ifid_flush=idex_flush=1, for_a_e=for_b_e=0. After release with NOPs: pc_en=ifid_en=1, no flushes.
- **ALU forward, both operands.** inst_e=add x5,x1,x2 with reg_write_e=1; inst_d=sub x6,x5,x5 -> after one edge, for_a_e=for_b_e=1, stall=0.
- **x0 and non-user cases.**
  - inst_e writes x0 -> no forward.
  - inst_d=lui x7 with rs1 field=5 and rd_e=5 -> for_a_e=0.
- **Load-use, LOAD_LAT=1 and 3.** inst_e=lw x5, inst_d=add x6,x5,x1 -> stall=1 with pc_en=0 and idex_flush=1 for exactly 1 and 3 cycles respectively. The dependent instruction then enters execute with for_a_e=0.
- **Branch taken.** br_taken=1 in RUN -> ifid_flush=idex_flush=1 for one cycle and for_*_e cleared. Forced br_taken=1 during LDSTALL aborts the stall: next cycle state RUN, pc_en=1.
- **Perf counters (HAZARD_CTRL_PERF_EN).** 2 load-use hazards at LOAD_LAT=3 plus 1 taken branch -> stall_cnt=6, flush_cnt=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute instruction view in, pipeline-register controls out.
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
   logic [31:0] inst_d;
   logic [31:0] inst_e;
   logic        reg_write_e;
   logic        br_taken;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        for_a_e;
   logic        for_b_e;
   logic        stall;

   modport master (
      output inst_d, inst_e, reg_write_e, br_taken,
      input  pc_en, ifid_en, ifid_flush, idex_flush, for_a_e, for_b_e, stall
   );

   modport slave (
      input  inst_d, inst_e, reg_write_e, br_taken,
      output pc_en, ifid_en, ifid_flush, idex_flush, for_a_e, for_b_e, stall
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 3-stage RV32I core: load-use stalls, taken-branch flushes, forward selects.
// Optional HAZARD_CTRL_PERF_EN adds free-running stall_cnt / flush_cnt outputs.
module hazard_ctrl #(
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   flush_cnt
`endif
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [2:0] CNT_INIT  = 3'(LOAD_LAT - 1);

   typedef enum logic {RUN, LDSTALL} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       for_a_q, for_a_d;
   logic       for_b_q, for_b_d;

   logic [6:0] opc_d, opc_e;
   logic [4:0] rs1_d, rs2_d, rd_e;
   logic       uses_rs1, uses_rs2, prod_ok, fwd_prod, load_prod;
   logic       m_rs1, m_rs2, fwd_a, fwd_b, load_hit;
   logic       pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, stall_c;

   assign opc_d = hz.inst_d[6:0];
   assign rs1_d = hz.inst_d[19:15];
   assign rs2_d = hz.inst_d[24:20];
   assign opc_e = hz.inst_e[6:0];
   assign rd_e  = hz.inst_e[11:7];

   logic unused_inst_bits;
   assign unused_inst_bits = ^{hz.inst_d[31:25], hz.inst_d[14:7], hz.inst_e[31:12]};

   // Source-usage and producer classification; unknown producers never match.
   always_comb begin
      uses_rs1  = !(opc_d == OP_LUI || opc_d == OP_AUIPC || opc_d == OP_JAL);
      uses_rs2  = (opc_d == OP_REG) || (opc_d == OP_STORE) || (opc_d == OP_BRANCH);
      prod_ok   = hz.reg_write_e && (rd_e != 5'd0);
      fwd_prod  = (opc_e == OP_REG) || (opc_e == OP_IMM) ||
                  (opc_e == OP_LUI) || (opc_e == OP_AUIPC);
      load_prod = (opc_e == OP_LOAD);
      m_rs1     = prod_ok && uses_rs1 && (rs1_d == rd_e);
      m_rs2     = prod_ok && uses_rs2 && (rs2_d == rd_e);
      fwd_a     = m_rs1 && fwd_prod;
      fwd_b     = m_rs2 && fwd_prod;
      load_hit  = (m_rs1 || m_rs2) && load_prod;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_en_c      = 1'b1;
      ifid_en_c    = 1'b1;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      stall_c      = 1'b0;

      // A taken branch wins even inside LDSTALL, so a stray stall can never wedge the pipe.
      if (hz.br_taken) begin
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
         state_d      = RUN;
         cnt_d        = 3'd0;
      end else if (state_q == LDSTALL) begin
         stall_c      = 1'b1;
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         idex_flush_c = 1'b1;
         cnt_d        = cnt_q - 3'd1;
         if (cnt_d == 3'd0) state_d = RUN;
      end else if (load_hit) begin
         stall_c      = 1'b1;
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         idex_flush_c = 1'b1;
         cnt_d        = CNT_INIT;
         state_d      = (LOAD_LAT == 1) ? RUN : LDSTALL;
      end

      if (!rst_n) begin
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
         stall_c      = 1'b0;
      end

      // Forward selects follow the instruction into ID/EX; a bubble carries none.
      for_a_d = for_a_q;
      for_b_d = for_b_q;
      if (idex_flush_c) begin
         for_a_d = 1'b0;
         for_b_d = 1'b0;
      end else if (ifid_en_c) begin
         for_a_d = fwd_a;
         for_b_d = fwd_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         for_a_q <= 1'b0;
         for_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for_a_q <= for_a_d;
         for_b_q <= for_b_d;
      end
   end

   assign hz.pc_en      = pc_en_c;
   assign hz.ifid_en    = ifid_en_c;
   assign hz.ifid_flush = ifid_flush_c;
   assign hz.idex_flush = idex_flush_c;
   assign hz.stall      = stall_c;
   assign hz.for_a_e    = for_a_q;
   assign hz.for_b_e    = for_b_q;

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall_c};
      flush_cnt_d = flush_cnt_q + {31'd0, ifid_flush_c};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus stream.
module tb_hazard_ctrl;

   localparam logic [31:0] NOP       = 32'h0000_0013; // addi x0,x0,0
   localparam logic [31:0] ADD_5_1_2 = 32'h0020_82B3; // add x5,x1,x2
   localparam logic [31:0] SUB_6_5_5 = 32'h4052_8333; // sub x6,x5,x5
   localparam logic [31:0] ADD_0_1_2 = 32'h0020_8033; // add x0,x1,x2
   localparam logic [31:0] SUB_6_0_0 = 32'h4000_0333; // sub x6,x0,x0
   localparam logic [31:0] LUI_7_R5  = 32'h0002_83B7; // lui x7, rs1 field = 5
   localparam logic [31:0] ADD_6_1_5 = 32'h0050_8333; // add x6,x1,x5
   localparam logic [31:0] LW_5      = 32'h0000_A283; // lw x5,0(x1)
   localparam logic [31:0] ADD_6_5_1 = 32'h0012_8333; // add x6,x5,x1

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if if1();
   hazard_ctrl_if if3();

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] sc1, fc1, sc3, fc3;
`endif

   hazard_ctrl #(.LOAD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .hz(if1)
`ifdef HAZARD_CTRL_PERF_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   hazard_ctrl #(.LOAD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .hz(if3)
`ifdef HAZARD_CTRL_PERF_EN
      , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] id, input logic [31:0] ie, input logic rw, input logic br);
      if1.inst_d = id; if1.inst_e = ie; if1.reg_write_e = rw; if1.br_taken = br;
      if3.inst_d = id; if3.inst_e = ie; if3.reg_write_e = rw; if3.br_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(NOP, NOP, 1'b0, 1'b0);

      // Reset values
      tick();
      chk("rst_pc_en",      if3.pc_en,      1'b0);
      chk("rst_ifid_en",    if3.ifid_en,    1'b0);
      chk("rst_ifid_flush", if3.ifid_flush, 1'b1);
      chk("rst_idex_flush", if3.idex_flush, 1'b1);
      chk("rst_stall",      if3.stall,      1'b0);
      chk("rst_for_a",      if3.for_a_e,    1'b0);
      chk("rst_for_b",      if3.for_b_e,    1'b0);

      rst_n = 1'b1;
      #1;
      chk("rel_pc_en",      if3.pc_en,      1'b1);
      chk("rel_ifid_en",    if3.ifid_en,    1'b1);
      chk("rel_ifid_flush", if3.ifid_flush, 1'b0);
      chk("rel_idex_flush", if3.idex_flush, 1'b0);

      // ALU forward on both operands
      drive(SUB_6_5_5, ADD_5_1_2, 1'b1, 1'b0);
      chk("alu_stall", if3.stall, 1'b0);
      chk("alu_pc_en", if3.pc_en, 1'b1);
      tick();
      chk("alu_for_a", if3.for_a_e, 1'b1);
      chk("alu_for_b", if3.for_b_e, 1'b1);

      // x0 destination never forwards
      drive(SUB_6_0_0, ADD_0_1_2, 1'b1, 1'b0);
      tick();
      chk("x0_for_a", if3.for_a_e, 1'b0);
      chk("x0_for_b", if3.for_b_e, 1'b0);

      // LUI does not read rs1 even when the field matches
      drive(LUI_7_R5, ADD_5_1_2, 1'b1, 1'b0);
      tick();
      chk("lui_for_a", if3.for_a_e, 1'b0);

      // rs2-only match
      drive(ADD_6_1_5, ADD_5_1_2, 1'b1, 1'b0);
      tick();
      chk("rs2_for_a", if3.for_a_e, 1'b0);
      chk("rs2_for_b", if3.for_b_e, 1'b1);

      // Producer without reg_write
      drive(SUB_6_5_5, ADD_5_1_2, 1'b0, 1'b0);
      tick();
      chk("nowr_for_a", if3.for_a_e, 1'b0);
      chk("nowr_for_b", if3.for_b_e, 1'b0);

      // Taken branch clears pending forward selects
      drive(SUB_6_5_5, ADD_5_1_2, 1'b1, 1'b0);
      tick();
      chk("prebr_for_a", if3.for_a_e, 1'b1);
      drive(SUB_6_5_5, ADD_5_1_2, 1'b1, 1'b1);
      chk("br_ifid_flush", if3.ifid_flush, 1'b1);
      chk("br_idex_flush", if3.idex_flush, 1'b1);
      chk("br_pc_en",      if3.pc_en,      1'b1);
      chk("br_stall",      if3.stall,      1'b0);
      tick();
      chk("br_for_a", if3.for_a_e, 1'b0);
      chk("br_for_b", if3.for_b_e, 1'b0);
      drive(NOP, NOP, 1'b0, 1'b0);
      chk("postbr_ifid_flush", if3.ifid_flush, 1'b0);

      // Load-use: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 stalls three
      drive(ADD_6_5_1, LW_5, 1'b1, 1'b0);
      chk("ld1_c1_stall", if1.stall,      1'b1);
      chk("ld3_c1_stall", if3.stall,      1'b1);
      chk("ld3_c1_pc_en", if3.pc_en,      1'b0);
      chk("ld3_c1_ifid",  if3.ifid_en,    1'b0);
      chk("ld3_c1_idexf", if3.idex_flush, 1'b1);
      chk("ld3_c1_ifidf", if3.ifid_flush, 1'b0);
      tick();
      drive(ADD_6_5_1, NOP, 1'b0, 1'b0);
      chk("ld1_c2_stall", if1.stall, 1'b0);
      chk("ld1_c2_pc_en", if1.pc_en, 1'b1);
      chk("ld3_c2_stall", if3.stall, 1'b1);
      chk("ld3_c2_pc_en", if3.pc_en, 1'b0);
      tick();
      chk("ld1_dep_for_a", if1.for_a_e, 1'b0);
      chk("ld3_c3_stall",  if3.stall,   1'b1);
      chk("ld3_c3_idexf",  if3.idex_flush, 1'b1);
      tick();
      chk("ld3_c4_stall", if3.stall,      1'b0);
      chk("ld3_c4_pc_en", if3.pc_en,      1'b1);
      chk("ld3_c4_idexf", if3.idex_flush, 1'b0);
      tick();
      chk("ld3_dep_for_a", if3.for_a_e, 1'b0);

      // Taken branch inside LDSTALL aborts the stall
      drive(ADD_6_5_1, LW_5, 1'b1, 1'b0);
      chk("ab_c1_stall", if3.stall, 1'b1);
      tick();
      drive(ADD_6_5_1, NOP, 1'b0, 1'b1);
      chk("ab_stall",      if3.stall,      1'b0);
      chk("ab_pc_en",      if3.pc_en,      1'b1);
      chk("ab_ifid_flush", if3.ifid_flush, 1'b1);
      tick();
      drive(ADD_6_5_1, NOP, 1'b0, 1'b0);
      chk("ab_run_stall", if3.stall, 1'b0);
      chk("ab_run_pc_en", if3.pc_en, 1'b1);

      // Reset asserted mid-stall
      drive(ADD_6_5_1, LW_5, 1'b1, 1'b0);
      tick();
      drive(ADD_6_5_1, NOP, 1'b0, 1'b0);
      chk("mid_stall_pre", if3.stall, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pc_en", if3.pc_en,      1'b0);
      chk("mid_rst_ifidf", if3.ifid_flush, 1'b1);
      chk("mid_rst_idexf", if3.idex_flush, 1'b1);
      chk("mid_rst_stall", if3.stall,      1'b0);
      chk("mid_rst_for_a", if3.for_a_e,    1'b0);
      chk("mid_rst_for_b", if3.for_b_e,    1'b0);
      drive(NOP, NOP, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rel_pc_en", if3.pc_en,      1'b1);
      chk("mid_rel_ifid",  if3.ifid_en,    1'b1);
      chk("mid_rel_ifidf", if3.ifid_flush, 1'b0);
      chk("mid_rel_idexf", if3.idex_flush, 1'b0);
      chk("mid_rel_stall", if3.stall,      1'b0);

`ifdef HAZARD_CTRL_PERF_EN
      // Two load-use hazards plus one taken branch on the LOAD_LAT=3 instance
      for (int k = 0; k < 2; k++) begin
         drive(ADD_6_5_1, LW_5, 1'b1, 1'b0);
         tick();
         drive(ADD_6_5_1, NOP, 1'b0, 1'b0);
         tick();
         tick();
         drive(NOP, NOP, 1'b0, 1'b0);
      end
      drive(NOP, NOP, 1'b0, 1'b1);
      tick();
      drive(NOP, NOP, 1'b0, 1'b0);
      tick();
      chk32("perf_stall_cnt", sc3, 32'd6);
      chk32("perf_flush_cnt", fc3, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
